addr_sel_pipe: RTL and testbench

ADDR_SEL_PIPE -- requirements
Module: addr_sel_pipe

---
 rtl/addr_sel_pkg.sv | 17 +
 rtl/addr_sel_mux.sv | 26 ++
 rtl/addr_sel_pipe.sv | 115 +++++++++++
 tb/tb_addr_sel_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_sel_pkg.sv
// Shared types and constants for the address select pipeline.
// State encodings, error counter limit and a saturating increment helper.
package addr_sel_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == ERR_CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/addr_sel_mux.sv
// Parametrised N-input address mux with range check.
// An out-of-range select yields a zero address and raises err.
module addr_sel_mux #(
  parameter int DW  = 5,
  parameter int NIN = 4,
  parameter int SW  = 2
) (
  input  logic [SW-1:0]     sel,
  input  logic [NIN*DW-1:0] data_in,
  output logic [DW-1:0]     addr,
  output logic              err
);

  // Pick the matching candidate; fall through to zero plus error.
  always_comb begin
    addr = '0;
    err  = 1'b1;
    for (int i = 0; i < NIN; i++) begin
      if (sel == SW'(i)) begin
        addr = data_in[i*DW +: DW];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/addr_sel_pipe.sv
// One-cycle registered address select with valid/ready handshake.
// Define ADDR_SEL_PIPE_SKID_EN for a skid register and registered in_ready.
module addr_sel_pipe
  import addr_sel_pkg::*;
#(
  parameter int DW  = 5,
  parameter int NIN = 4,
  parameter int SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SW-1:0]     sel,
  input  logic [NIN*DW-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     data_out,
  output logic              sel_err,
  output logic [7:0]        err_cnt
);

  state_t        state;
  logic [DW-1:0] main_data;
  logic          main_err;
  logic [DW-1:0] res_addr;
  logic          res_err;
  logic          in_xfer;
  logic          out_xfer;

`ifdef ADDR_SEL_PIPE_SKID_EN
  logic [DW-1:0] skid_data;
  logic          skid_err;
`endif

  addr_sel_mux #(
    .DW  (DW),
    .NIN (NIN),
    .SW  (SW)
  ) u_mux (
    .sel     (sel),
    .data_in (data_in),
    .addr    (res_addr),
    .err     (res_err)
  );

  assign out_valid = (state != EMPTY);
`ifdef ADDR_SEL_PIPE_SKID_EN
  assign in_ready  = rst_n && (state != TWO);
`else
  assign in_ready  = rst_n && (!out_valid || out_ready);
`endif
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign data_out  = main_data;
  assign sel_err   = main_err;

  // Occupancy FSM, result registers and error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      err_cnt   <= '0;
`ifdef ADDR_SEL_PIPE_SKID_EN
      skid_data <= '0;
      skid_err  <= 1'b0;
`endif
    end else begin
      if (in_xfer && res_err)
        err_cnt <= sat_inc(err_cnt);
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data <= res_addr;
            main_err  <= res_err;
            state     <= ONE;
          end
        end
        ONE: begin
`ifdef ADDR_SEL_PIPE_SKID_EN
          if (in_xfer && !out_xfer) begin
            skid_data <= res_addr;
            skid_err  <= res_err;
            state     <= TWO;
          end else if (in_xfer) begin
            main_data <= res_addr;
            main_err  <= res_err;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
`else
          if (in_xfer) begin
            main_data <= res_addr;
            main_err  <= res_err;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
`endif
        end
`ifdef ADDR_SEL_PIPE_SKID_EN
        TWO: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            state     <= ONE;
          end
        end
`endif
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_sel_pipe.sv
// Directed testbench for addr_sel_pipe (NIN=4 and NIN=3 instances).
// Skid-dependent expectations follow ADDR_SEL_PIPE_SKID_EN.
module tb_addr_sel_pipe;

`ifdef ADDR_SEL_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  sel;
  logic [19:0] data_in;
  logic [4:0]  data_out;
  logic        sel_err;
  logic [7:0]  err_cnt;

  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [1:0]  sel3;
  logic [14:0] data_in3;
  logic [4:0]  data_out3;
  logic        sel_err3;
  logic [7:0]  err_cnt3;

  int checks = 0;
  int errors = 0;
  logic [4:0] vals [4] = '{5'd9, 5'd17, 5'd2, 5'd31};

  always #5 clk = ~clk;

  addr_sel_pipe u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  addr_sel_pipe #(.DW(5), .NIN(3), .SW(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .data_in   (data_in3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .data_out  (data_out3),
    .sel_err   (sel_err3),
    .err_cnt   (err_cnt3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
    data_in = {5'd31, 5'd2, 5'd17, 5'd9};
    in_valid3 = 1'b0; out_ready3 = 1'b0; sel3 = 2'd0;
    data_in3 = {5'd7, 5'd6, 5'd5};
    tick; tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %0d exp 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got %0d exp 0", in_ready);
    end
    checks++;
    if (data_out !== 5'd0) begin
      errors++; $display("FAIL rst_data_out got %0d exp 0", data_out);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      errors++; $display("FAIL rst_sel_err got %0d exp 0", sel_err);
    end
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt);
    end
    checks++;
    if (err_cnt3 !== 8'd0) begin
      errors++; $display("FAIL rst_err_cnt3 got %0d exp 0", err_cnt3);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_in_ready got %0d exp 1", in_ready);
    end
    checks++;
    if (in_ready3 !== 1'b1) begin
      errors++; $display("FAIL post_rst_in_ready3 got %0d exp 1", in_ready3);
    end
  endtask

  task automatic test_select;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick;
      checks++;
      if (out_valid !== 1'b1 || data_out !== vals[i] || sel_err !== 1'b0) begin
        errors++;
        $display("FAIL select%0d got v=%0d d=%0d e=%0d exp v=1 d=%0d e=0",
                 i, out_valid, data_out, sel_err, vals[i]);
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL select_drain got %0d exp 0", out_valid);
    end
  endtask

  task automatic test_err;
    out_ready3 = 1'b1;
    in_valid3 = 1'b1;
    sel3 = 2'd3;
    tick;
    checks++;
    if (out_valid3 !== 1'b1 || data_out3 !== 5'd0 || sel_err3 !== 1'b1) begin
      errors++;
      $display("FAIL err_result got v=%0d d=%0d e=%0d exp v=1 d=0 e=1",
               out_valid3, data_out3, sel_err3);
    end
    checks++;
    if (err_cnt3 !== 8'd1) begin
      errors++; $display("FAIL err_cnt_one got %0d exp 1", err_cnt3);
    end
    sel3 = 2'd2;
    tick;
    checks++;
    if (data_out3 !== 5'd7 || sel_err3 !== 1'b0 || err_cnt3 !== 8'd1) begin
      errors++;
      $display("FAIL err_inrange got d=%0d e=%0d c=%0d exp d=7 e=0 c=1",
               data_out3, sel_err3, err_cnt3);
    end
    sel3 = 2'd3;
    for (int k = 2; k <= 300; k++) begin
      tick;
      if (k == 254) begin
        checks++;
        if (err_cnt3 !== 8'd254) begin
          errors++; $display("FAIL err_cnt_254 got %0d exp 254", err_cnt3);
        end
      end
      if (k == 255) begin
        checks++;
        if (err_cnt3 !== 8'd255) begin
          errors++; $display("FAIL err_cnt_255 got %0d exp 255", err_cnt3);
        end
      end
    end
    checks++;
    if (err_cnt3 !== 8'd255) begin
      errors++; $display("FAIL err_cnt_sat got %0d exp 255", err_cnt3);
    end
    in_valid3 = 1'b0;
    tick;
  endtask

  task automatic test_stall;
    in_valid = 1'b1; sel = 2'd0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_rdy0 got %0d exp 1", in_ready);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 5'd9) begin
      errors++;
      $display("FAIL stall_first got v=%0d d=%0d exp v=1 d=9", out_valid, data_out);
    end
    sel = 2'd1;
    #1;
    checks++;
    if (in_ready !== SKID) begin
      errors++; $display("FAIL stall_rdy1 got %0d exp %0d", in_ready, SKID);
    end
    tick;
    checks++;
    if (out_valid !== 1'b1 || data_out !== 5'd9) begin
      errors++;
      $display("FAIL stall_hold1 got v=%0d d=%0d exp v=1 d=9", out_valid, data_out);
    end
    sel = 2'd2;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_rdy2 got %0d exp 0", in_ready);
    end
    tick;
    checks++;
    if (data_out !== 5'd9) begin
      errors++; $display("FAIL stall_hold2 got %0d exp 9", data_out);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== !SKID) begin
      errors++; $display("FAIL stall_rdy3 got %0d exp %0d", in_ready, !SKID);
    end
    tick;
    checks++;
    if (out_valid !== SKID || (SKID && data_out !== 5'd17)) begin
      errors++;
      $display("FAIL stall_drain1 got v=%0d d=%0d exp v=%0d d=17",
               out_valid, data_out, SKID);
    end
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drain2 got %0d exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel = 2'(i % 4);
      tick;
      checks++;
      if (out_valid !== 1'b1 || data_out !== vals[i % 4]) begin
        errors++;
        $display("FAIL b2b%0d got v=%0d d=%0d exp v=1 d=%0d",
                 i, out_valid, data_out, vals[i % 4]);
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got %0d exp 0", out_valid);
    end
  endtask

  task automatic test_toggle;
    logic [4:0] q [$];
    logic       exp_rdy;
    in_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      sel = 2'((c * 3) % 4);
      out_ready = (c % 2 == 0);
      #1;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL tog_rdy%0d got %0d exp %0d", c, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL tog_vld%0d got %0d exp %0d", c, out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (data_out !== q[0]) begin
          errors++; $display("FAIL tog_data%0d got %0d exp %0d", c, data_out, q[0]);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (exp_rdy) q.push_back(vals[(c * 3) % 4]);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (q.size() != 0) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== q[0]) begin
          errors++;
          $display("FAIL tog_drain%0d got v=%0d d=%0d exp v=1 d=%0d",
                   k, out_valid, data_out, q[0]);
        end
        void'(q.pop_front());
        tick;
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL tog_empty got %0d exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick;
    sel = 2'd1;
    tick;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full got v=%0d r=%0d exp v=1 r=0", out_valid, in_ready);
    end
    rst_n = 1'b0; in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0 || data_out !== 5'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got v=%0d d=%0d r=%0d exp 0 0 0",
               out_valid, data_out, in_ready);
    end
    checks++;
    if (err_cnt !== 8'd0 || err_cnt3 !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", err_cnt, err_cnt3);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_post_rdy got %0d exp 1", in_ready);
    end
    out_ready = 1'b1;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_emit got %0d exp 0", out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_select;
    test_err;
    test_stall;
    test_back_to_back;
    test_toggle;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
